adc_capture_core: RTL
=====================

# adc_capture_core

Capture engine for the ADC side of the analog front end, the receive counterpart of the DAC output path. Generates the ADC sample clock, registers the parallel ADC word on each sample, and buffers samples in a small FIFO. The FIFO is drained by the PLB slave register logic through a single-cycle read handshake. Also reports status and a completion interrupt.

## Interface
- ADC_WIDTH, 10, ADC data width (2..16)
- FIFO_DEPTH, 16, sample FIFO depth; power of 2, >= 4
- DIV_WIDTH, 8, width of the clock-divider control
- SPLB_Clk  in  1  system clock; all logic on rising edge
- SPLB_Rst_n  in  1  asynchronous, active-low reset
- S_Data  in  ADC_WIDTH  ADC parallel output
- S_Clkout  out  1  ADC sample clock
- S_PWRDN  out  1  ADC power-down, active high
- Ctrl_Start  in  1  pulse: flush FIFO, clear status, begin capture
- Ctrl_Stop  in  1  pulse: abort capture
- Ctrl_Div  in  DIV_WIDTH  half-period of S_Clkout minus 1, in SPLB_Clk cycles
- Ctrl_Count  in  16  samples to capture; 0 = continuous
- Rd_Req  in  1  pop one FIFO entry
- Rd_Ack  out  1  read response strobe
- Rd_Data  out  32  bit 31 = valid; low bits = sample
- Stat_Busy  out  1  capture in progress
- Stat_Done  out  1  sticky; count reached
- Stat_Overflow  out  1  sticky; sample dropped on full FIFO
- Stat_Level  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- IRQ  out  1  one-cycle pulse on entry to DONE

## Operation
- States:
  - IDLE, RUN, DONE.
  - Reset → IDLE.
- Start in IDLE or DONE:
  - → RUN.
  - Latches Ctrl_Div and Ctrl_Count.
  - Flushes the FIFO; clears Stat_Done, Stat_Overflow, the divider counter and the sample counter.
  - S_Clkout = 0.
- Start while in RUN is ignored.
- Stop in any state:
  - → IDLE.
  - S_Clkout = 0 on the next edge.
  - FIFO contents retained; no IRQ.
- Start and Stop in the same cycle: Stop wins.
- Divider in RUN:
  - Counts 0..Div.
  - At terminal count: S_Clkout toggles and the counter returns to 0.
  - Sample period = 2·(Div+1) cycles.
- Sample strobe: the edge on which S_Clkout goes 1→0. On that edge S_Data is written to the FIFO and the sample counter increments.
- FIFO full at strobe:
  - Sample dropped; Stat_Overflow set.
  - Sample counter still increments.
- Counter == Count (Count ≠ 0):
  - → DONE.
  - S_Clkout forced 0; Stat_Done = 1; IRQ pulses 1 cycle.
- S_PWRDN = 0 in RUN only; 1 in IDLE and DONE.
- Stat_Busy = (state == RUN).
- Read: each cycle Rd_Req = 1 pops one entry, in any state.
  - Non-empty: Rd_Data = {1, sample}.
  - Empty: Rd_Data = 0x0000_0000.
- Pop and push in the same cycle: the pop is evaluated first.
  - When full, the push is accepted; no overflow.
  - When empty, the read returns empty; no bypass.
- Stat_Level wraps correctly through pointer wrap-around and reaches FIFO_DEPTH when full.

## Timing
- Reset values: S_Clkout 0, S_PWRDN 1, Rd_Ack 0, Rd_Data 0, all Stat_* 0, IRQ 0, FIFO empty.
- Start sampled at edge t: state = RUN from t.
- S_Clkout first rises at edge t+Div+1 and first falls (first sample) at edge t+2(Div+1).
- Rd_Ack is asserted one cycle after Rd_Req, with Rd_Data valid in the same cycle; both are registered.
- Stat_Level updates on the edge following a push or pop.
- IRQ coincides with the first cycle of DONE.
- Reset mid-capture: everything returns to reset values immediately (asynchronous assert), including FIFO contents.

## Configuration
- ADC_CAPTURE_TWOS_COMP_EN
  - Defined: the sample MSB is inverted (offset binary → two's complement) and sign-extended into Rd_Data[30:0].
  - Undefined: the sample is zero-extended into Rd_Data[30:0] unchanged.
- Bit 31 is the valid flag in both builds.

## Test plan
- Reset release, no stimulus:
  - S_PWRDN 1, S_Clkout 0, Stat_Level 0.
  - Rd_Req → Rd_Ack one cycle later with Rd_Data 0x0000_0000.
- Div=1, Count=4, S_Data = 0x000, 0x001, … changing each SPLB_Clk period (S_Data = cycle index):
  - S_Clkout period 4 cycles; samples taken at t+4, 8, 12, 16.
  - Reads return 0x8000_0004, 0x8000_0008, 0x8000_000C, 0x8000_0010 (macro undefined).
  - DONE and IRQ pulse at t+16.
- Div=0, Count=0, FIFO_DEPTH=16, no reads for 40 cycles: Stat_Level = 16 and Stat_Overflow = 1.
- Full FIFO with Rd_Req on a strobe edge: push accepted; Stat_Level stays 16; Stat_Overflow not set.
- S_Data = 0x200 (ADC_WIDTH=10):
  - Macro defined: read returns 0x8000_0000.
  - S_Data = 0x1FF: read returns 0xFFFF_FFFF.
  - Macro undefined, S_Data = 0x1FF: read returns 0x8000_01FF.
- Mid-capture events:
  - Stop mid-capture: IDLE next cycle, S_Clkout 0, no IRQ, FIFO kept.
  - Start and Stop together: IDLE, FIFO not flushed.
  - SPLB_Rst_n pulse mid-capture: all outputs return to reset values immediately.

Source files
------------

// File: rtl/adc_capture_core.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_core
// Purpose  : ADC receive capture engine. Generates the ADC sample clock from
//            SPLB_Clk, captures the parallel ADC word on every falling edge
//            of that clock, and buffers the samples in a small FIFO. The
//            register logic drains the FIFO with a single-cycle read
//            handshake. Reports busy/done/overflow/level status and a
//            one-cycle completion interrupt.
// Macro    : ADC_CAPTURE_TWOS_COMP_EN
//              defined   - offset-binary sample converted to two's
//                          complement and sign-extended into Rd_Data[30:0]
//              undefined - sample zero-extended into Rd_Data[30:0]
// Ports    : SPLB_Clk, SPLB_Rst_n       clock, async active-low reset
//            S_Data / S_Clkout / S_PWRDN ADC data in, sample clock, power-down
//            Ctrl_Start / Ctrl_Stop      capture start / abort pulses
//            Ctrl_Div                    sample-clock half period minus 1
//            Ctrl_Count                  samples to capture (0 = continuous)
//            Rd_Req / Rd_Ack / Rd_Data   FIFO pop handshake, bit 31 = valid
//            Stat_Busy / Stat_Done / Stat_Overflow / Stat_Level, IRQ
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_core #(
  parameter int ADC_WIDTH  = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                            SPLB_Clk,
  input  logic                            SPLB_Rst_n,
  input  logic [ADC_WIDTH-1:0]            S_Data,
  output logic                            S_Clkout,
  output logic                            S_PWRDN,
  input  logic                            Ctrl_Start,
  input  logic                            Ctrl_Stop,
  input  logic [DIV_WIDTH-1:0]            Ctrl_Div,
  input  logic [15:0]                     Ctrl_Count,
  input  logic                            Rd_Req,
  output logic                            Rd_Ack,
  output logic [31:0]                     Rd_Data,
  output logic                            Stat_Busy,
  output logic                            Stat_Done,
  output logic                            Stat_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]     Stat_Level,
  output logic                            IRQ
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [15:0]          count_q;
  logic [15:0]          sample_cnt;

  logic [ADC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]      wr_ptr;
  logic [ADDR_W:0]      rd_ptr;

  logic                 start_go;
  logic                 strobe;
  logic                 done_hit;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 overflow_evt;
  logic [ADC_WIDTH-1:0] head;
  logic [30:0]          head_ext;

  // Extra pointer bit distinguishes full from empty; the difference is the
  // occupancy and stays correct across pointer wrap-around.
  assign Stat_Level = wr_ptr - rd_ptr;
  assign empty      = (Stat_Level == '0);
  assign full       = (Stat_Level == LEVEL_FULL);

  assign Stat_Busy  = (state == ST_RUN);
  assign S_PWRDN    = (state != ST_RUN);

  // Stop overrides both a start and a sample falling on the same edge.
  assign start_go = Ctrl_Start && !Ctrl_Stop && (state != ST_RUN);
  assign strobe   = (state == ST_RUN) && !Ctrl_Stop &&
                    (div_cnt == div_q) && S_Clkout;
  assign done_hit = strobe && (count_q != 16'd0) &&
                    ((sample_cnt + 16'd1) == count_q);

  // Pop is evaluated before push: a full FIFO being read still accepts the
  // new sample, and an empty FIFO being written still reads back empty.
  assign pop          = Rd_Req && !empty;
  assign push         = strobe && (!full || pop);
  assign overflow_evt = strobe && full && !pop;

  assign head = mem[rd_ptr[ADDR_W-1:0]];

`ifdef ADC_CAPTURE_TWOS_COMP_EN
  logic [ADC_WIDTH-1:0] head_tc;
  // Offset binary to two's complement is a flip of the MSB.
  assign head_tc  = head ^ {1'b1, {(ADC_WIDTH-1){1'b0}}};
  assign head_ext = {{(31-ADC_WIDTH){head_tc[ADC_WIDTH-1]}}, head_tc};
`else
  assign head_ext = {{(31-ADC_WIDTH){1'b0}}, head};
`endif

  // --------------------------------------------------------------------------
  // Capture control: state, divider, sample counter, sticky status, IRQ
  // --------------------------------------------------------------------------
  always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
    if (!SPLB_Rst_n) begin
      state         <= ST_IDLE;
      div_q         <= '0;
      div_cnt       <= '0;
      count_q       <= '0;
      sample_cnt    <= '0;
      S_Clkout      <= 1'b0;
      Stat_Done     <= 1'b0;
      Stat_Overflow <= 1'b0;
      IRQ           <= 1'b0;
    end else begin
      IRQ <= 1'b0;
      if (Ctrl_Stop) begin
        state    <= ST_IDLE;
        S_Clkout <= 1'b0;
      end else if (start_go) begin
        state         <= ST_RUN;
        div_q         <= Ctrl_Div;
        count_q       <= Ctrl_Count;
        div_cnt       <= '0;
        sample_cnt    <= '0;
        S_Clkout      <= 1'b0;
        Stat_Done     <= 1'b0;
        Stat_Overflow <= 1'b0;
      end else if (state == ST_RUN) begin
        if (div_cnt == div_q) begin
          div_cnt  <= '0;
          S_Clkout <= ~S_Clkout;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (strobe) begin
          sample_cnt <= sample_cnt + 16'd1;
        end
        if (overflow_evt) begin
          Stat_Overflow <= 1'b1;
        end
        if (done_hit) begin
          state     <= ST_DONE;
          S_Clkout  <= 1'b0;
          Stat_Done <= 1'b1;
          IRQ       <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and read response
  // --------------------------------------------------------------------------
  always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
    if (!SPLB_Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      Rd_Ack  <= 1'b0;
      Rd_Data <= '0;
    end else begin
      Rd_Ack <= Rd_Req;
      if (pop) begin
        Rd_Data <= {1'b1, head_ext};
      end else begin
        Rd_Data <= '0;
      end
      if (start_go) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: clearing the pointers empties the FIFO.
  always_ff @(posedge SPLB_Clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= S_Data;
    end
  end

endmodule
`default_nettype wire
